bram_sdp_pipe: RTL and testbench
================================

// Module: bram_sdp_pipe
// PURPOSE
//  Simple-dual-port block RAM with per-lane write enables, read-valid tracking, write-to-read forwarding and a
//  post-reset clear sequencer. Parametrised successor of the team's plain BRAM. Used as line/frame storage
//  where reads need a qualified valid and memory must start zeroed.
// PARAMETERS
//  BRAM_ADDR_WIDTH  10  address bits; depth = 2**BRAM_ADDR_WIDTH
//  BRAM_DATA_WIDTH  32  word width; must be a multiple of BRAM_LANE_WIDTH
//  BRAM_LANE_WIDTH  8   bits per write-enable lane; NUM_LANES = BRAM_DATA_WIDTH/BRAM_LANE_WIDTH
//  CLEAR_VALUE      0   lane value written to every lane of every word during the clear sequence
// PORTS
//  clock      in   1                one clock; all logic on posedge
//  reset      in   1                synchronous, active-high
//  rd_en      in   1                read request
//  rd_addr    in   BRAM_ADDR_WIDTH  read address
//  wr_en      in   1                write request
//  wr_addr    in   BRAM_ADDR_WIDTH  write address
//  wr_be      in   NUM_LANES        per-lane write enable; lane i = din[i*LW +: LW]
//  din        in   BRAM_DATA_WIDTH  write data
//  dout       out  BRAM_DATA_WIDTH  read data, qualified by rd_valid
//  rd_valid   out  1                dout holds data for an accepted read
//  init_busy  out  1                clear sequence running; user requests ignored
// BEHAVIOUR
//  - Reset (sync, active-high): state<=CLEAR, clr_cnt<=0, init_busy<=1, rd_valid<=0, dout<=0. Array itself is not
//    reset; the clear sequence zeroes it. Reset asserted mid-operation or mid-clear restarts the clear from address 0
//    and drops any in-flight read (rd_valid=0 the cycle after reset is sampled).
//  - FSM states CLEAR, RUN. CLEAR: each cycle write CLEAR_VALUE to all lanes of mem[clr_cnt], clr_cnt++. When
//    clr_cnt==DEPTH-1 is written, next state RUN; init_busy falls on that same edge (exactly DEPTH cycles of
//    init_busy=1 after reset deasserts). RUN: terminal until reset.
//  - In CLEAR, rd_en/wr_en are ignored (no write, no rd_valid); no stalling, caller must wait for init_busy=0.
//  - Write (RUN): wr_en=1 updates only lanes with wr_be[i]=1 at edge; wr_be=0 is a no-op.
//  - Read (RUN): rd_en=1 at edge N -> dout/rd_valid valid after edge N+1 (latency 1). rd_en=0 -> rd_valid=0 next cycle,
//    dout holds last value (not cleared).
//  - Same-cycle read and write to same address: new-data semantics per lane: lanes with wr_be[i]=1 return din lane,
//    others return stored lane. Different addresses: independent.
//  - Full address range, no wrap logic beyond natural modulo of address width.
//  - Back-to-back reads every cycle sustain one result per cycle.
// CONFIGURATION
//  BRAM_OUT_REG_EN defined: extra output register after array/forward mux; read latency 2, rd_valid pipelined alongside,
//    both output stages reset to 0; forwarding still uses write state at the read-issue edge.
//  BRAM_OUT_REG_EN undefined: latency 1 as above, single output stage.
// STRUCTURE
//  - Package bram_pkg: state enum bram_state_e {CLEAR, RUN}; functions/localparams for DEPTH and NUM_LANES.
//  - Sub-module bram_lane_array: the raw lane-enabled storage (one write port with lane enables, one registered read
//    port, block-RAM style); top holds FSM, clear counter, write-port mux (clear vs user), forward compare/merge and
//    valid pipeline.
// TESTING
//  1. Reset 1 cycle then release -> init_busy=1 for exactly 1024 cycles (AW=10); then reading addr 0, 511, 1023
//     -> dout=32'h0, rd_valid=1 one cycle (two with BRAM_OUT_REG_EN) after rd_en.
//  2. wr 0x12 <- 32'hDEADBEEF be=4'hF; then wr 0x12 <- 32'h00000055 be=4'b0001; read 0x12 -> 32'hDEADBE55.
//  3. Same cycle rd_addr=wr_addr=0x40, stored 32'h11223344, din=32'hAABBCCDD be=4'b1010 -> dout=32'hAA22CC44.
//  4. rd_en and wr_en during init_busy (wr 0x5 <- 32'hFFFFFFFF) -> rd_valid stays 0; after clear, read 0x5 -> 0.
//  5. Reset asserted mid-stream with read in flight and clear at clr_cnt=300 -> rd_valid=0 next cycle, init_busy=1,
//     full 1024-cycle clear restarts; previously written 0x12 reads 0 afterwards.
//  6. Read every cycle addrs 0..15 after writing word=addr -> dout sequence 0..15, rd_valid continuously 1.

Source files
------------

// File: rtl/bram_pkg.sv
// bram_pkg: shared state type and sizing helpers for bram_sdp_pipe
//   bram_state_e   : CLEAR (post-reset zeroing) / RUN (user access)
//   bram_depth     : words for a given address width
//   bram_num_lanes : write-enable lanes for a given word/lane width
package bram_pkg;

    typedef enum logic {CLEAR, RUN} bram_state_e;

    function automatic int bram_depth(input int aw);
        return 1 << aw;
    endfunction

    function automatic int bram_num_lanes(input int dw, input int lw);
        return dw / lw;
    endfunction

endpackage

// File: rtl/bram_lane_array.sv
// bram_lane_array: raw block-RAM style storage, one lane-enabled write port, one registered read port
//   clock, reset : posedge clock; reset only clears the read register, never the array
//   we/waddr/wbe/wdata : write port, lane i = wdata[i*LW +: LW] written when wbe[i]
//   re/raddr     : read request; rdata updates one edge later and holds while re=0
//   rdata        : registered read data (old-data on a same-address write)
module bram_lane_array import bram_pkg::*; #(
    parameter int AW = 10,
    parameter int DW = 32,
    parameter int LW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW/LW-1:0] wbe,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    localparam int DEPTH = bram_depth(AW);
    localparam int NL = bram_num_lanes(DW, LW);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = re ? mem[raddr] : rdata_q;
    end

    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < NL; i++) begin
                if (wbe[i]) mem[waddr][i*LW +: LW] <= wdata[i*LW +: LW];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) rdata_q <= '0;
        else rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bram_sdp_pipe.sv
// bram_sdp_pipe: simple-dual-port BRAM with lane write enables, read valid, write-to-read forwarding and post-reset clear
//   clock, reset (sync, active-high)
//   rd_en/rd_addr              : read request, result on dout qualified by rd_valid
//   wr_en/wr_addr/wr_be/din    : lane-enabled write
//   dout, rd_valid             : read data and its qualifier (dout holds between reads)
//   init_busy                  : clear sequence running, user requests ignored
//   Define BRAM_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module bram_sdp_pipe import bram_pkg::*; #(
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_LANE_WIDTH = 8,
    parameter logic [BRAM_LANE_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       rd_en,
    input  logic [BRAM_ADDR_WIDTH-1:0]                 rd_addr,
    input  logic                                       wr_en,
    input  logic [BRAM_ADDR_WIDTH-1:0]                 wr_addr,
    input  logic [BRAM_DATA_WIDTH/BRAM_LANE_WIDTH-1:0] wr_be,
    input  logic [BRAM_DATA_WIDTH-1:0]                 din,
    output logic [BRAM_DATA_WIDTH-1:0]                 dout,
    output logic                                       rd_valid,
    output logic                                       init_busy
);
    localparam int AW = BRAM_ADDR_WIDTH;
    localparam int DW = BRAM_DATA_WIDTH;
    localparam int LW = BRAM_LANE_WIDTH;
    localparam int NL = bram_num_lanes(DW, LW);

    bram_state_e   state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          init_busy_q, init_busy_d;
    logic          run, usr_we, usr_re;
    logic          arr_we;
    logic [AW-1:0] arr_waddr;
    logic [NL-1:0] arr_wbe;
    logic [DW-1:0] arr_wdata, arr_rdata, merged;
    logic [NL-1:0] fwd_mask_q, fwd_mask_d;
    logic [DW-1:0] fwd_data_q, fwd_data_d;
    logic          valid_q, valid_d;

    always_comb begin
        run         = state_q == RUN;
        // a request in the same cycle as reset must not touch the array or raise valid
        usr_we      = run && wr_en && !reset;
        usr_re      = run && rd_en && !reset;
        state_d     = (!run && &clr_cnt_q) ? RUN : state_q;
        clr_cnt_d   = run ? clr_cnt_q : clr_cnt_q + 1'b1;
        init_busy_d = state_d == CLEAR;
        arr_we      = run ? usr_we : 1'b1;
        arr_waddr   = run ? wr_addr : clr_cnt_q;
        arr_wbe     = run ? wr_be : '1;
        arr_wdata   = run ? din : {NL{CLEAR_VALUE}};
        // array reads old data; remember which lanes the same-edge write replaced
        fwd_mask_d  = usr_re ? ((usr_we && wr_addr == rd_addr) ? wr_be : '0) : fwd_mask_q;
        fwd_data_d  = usr_re ? din : fwd_data_q;
        valid_d     = usr_re;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            init_busy_q <= 1'b1;
            fwd_mask_q  <= '0;
            fwd_data_q  <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_busy_q <= init_busy_d;
            fwd_mask_q  <= fwd_mask_d;
            fwd_data_q  <= fwd_data_d;
            valid_q     <= valid_d;
        end
    end

    bram_lane_array #(.AW(AW), .DW(DW), .LW(LW)) u_array (
        .clock (clock),
        .reset (reset),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wbe   (arr_wbe),
        .wdata (arr_wdata),
        .re    (usr_re),
        .raddr (rd_addr),
        .rdata (arr_rdata)
    );

    for (genvar g = 0; g < NL; g++) begin : g_merge
        assign merged[g*LW +: LW] = fwd_mask_q[g] ? fwd_data_q[g*LW +: LW] : arr_rdata[g*LW +: LW];
    end

`ifdef BRAM_OUT_REG_EN
    logic [DW-1:0] dout_q, dout_d;
    logic          valid2_q, valid2_d;

    always_comb begin
        dout_d   = valid_q ? merged : dout_q;
        valid2_d = valid_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dout_q   <= '0;
            valid2_q <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            valid2_q <= valid2_d;
        end
    end

    assign dout     = dout_q;
    assign rd_valid = valid2_q;
`else
    assign dout     = merged;
    assign rd_valid = valid_q;
`endif

    assign init_busy = init_busy_q;

endmodule

// File: tb/tb_bram_sdp_pipe.sv
// tb_bram_sdp_pipe: scoreboard bench for bram_sdp_pipe (AW=10, DW=32, LW=8)
module tb_bram_sdp_pipe;
`ifdef BRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rd_en = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        rd_valid;
    logic        init_busy;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model [1024];

    bram_sdp_pipe dut (
        .clock     (clock),
        .reset     (reset),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_be     (wr_be),
        .din       (din),
        .dout      (dout),
        .rd_valid  (rd_valid),
        .init_busy (init_busy)
    );

    always #5 clock = ~clock;

    task automatic idle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask

    // waits out the clear (bounded) and zeroes the model to match
    task automatic wait_clear(output int n);
        n = 0;
        while (init_busy && n < 1100) begin
            idle();
            n++;
        end
        for (int i = 0; i < 1024; i++) model[i] = '0;
    endtask

    // one RUN-state cycle; a read pushes its expected word, a write updates the model
    task automatic issue(input logic r, input logic [9:0] ra, input logic w, input logic [9:0] wa,
                         input logic [3:0] be, input logic [31:0] d);
        logic [31:0] e;
        rd_en = r; rd_addr = ra; wr_en = w; wr_addr = wa; wr_be = be; din = d;
        if (r) begin
            e = model[ra];
            if (w && wa == ra)
                for (int i = 0; i < 4; i++) if (be[i]) e[i*8 +: 8] = d[i*8 +: 8];
            exp_q.push_back(e);
        end
        if (w)
            for (int i = 0; i < 4; i++) if (be[i]) model[wa][i*8 +: 8] = d[i*8 +: 8];
        idle();
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        logic [31:0] e;
        logic [9:0] addrs [3];
        addrs[0] = 10'd0; addrs[1] = 10'd511; addrs[2] = 10'd1023;
        do_reset();
        checks++;
        if (init_busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", init_busy); end
        checks++;
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
        checks++;
        if (dout !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
        wait_clear(n);
        checks++;
        if (n !== 1024) begin failures++; $display("FAIL clear_len got=%0d exp=1024", n); end
        foreach (addrs[k]) begin
            issue(1'b1, addrs[k], 1'b0, 10'd0, 4'h0, 32'h0);
            repeat (LAT-1) idle();
            e = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1) begin failures++; $display("FAIL clear_rd_valid a=%0d got=%b exp=1", addrs[k], rd_valid); end
            checks++;
            if (dout !== e) begin failures++; $display("FAIL clear_rd a=%0d got=%h exp=%h", addrs[k], dout, e); end
        end
    endtask

    task automatic test_lane_write();
        logic [31:0] e;
        issue(1'b0, 10'd0, 1'b1, 10'h12, 4'hF, 32'hDEADBEEF);
        issue(1'b0, 10'd0, 1'b1, 10'h12, 4'b0001, 32'h00000055);
        issue(1'b1, 10'h12, 1'b0, 10'd0, 4'h0, 32'h0);
        repeat (LAT-1) idle();
        e = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || dout !== e || e !== 32'hDEADBE55)
            begin failures++; $display("FAIL lane_write v=%b got=%h exp=%h", rd_valid, dout, e); end
        idle();
        checks++;
        if (rd_valid !== 1'b0 || dout !== e)
            begin failures++; $display("FAIL dout_hold v=%b got=%h exp=%h", rd_valid, dout, e); end
    endtask

    task automatic test_forward();
        logic [31:0] e;
        issue(1'b0, 10'd0, 1'b1, 10'h40, 4'hF, 32'h11223344);
        issue(1'b1, 10'h40, 1'b1, 10'h40, 4'b1010, 32'hAABBCCDD);
        repeat (LAT-1) idle();
        e = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || dout !== e || e !== 32'hAA22CC44)
            begin failures++; $display("FAIL forward v=%b got=%h exp=%h", rd_valid, dout, e); end
        issue(1'b1, 10'h40, 1'b1, 10'h41, 4'hF, 32'hCAFEF00D);
        repeat (LAT-1) idle();
        e = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || dout !== e)
            begin failures++; $display("FAIL diff_addr v=%b got=%h exp=%h", rd_valid, dout, e); end
        issue(1'b1, 10'h41, 1'b0, 10'd0, 4'h0, 32'h0);
        repeat (LAT-1) idle();
        e = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || dout !== e)
            begin failures++; $display("FAIL diff_addr_rd v=%b got=%h exp=%h", rd_valid, dout, e); end
    endtask

    task automatic test_busy_ignore();
        int n;
        logic [31:0] e;
        do_reset();
        rd_en = 1'b1; rd_addr = 10'h5; wr_en = 1'b1; wr_addr = 10'h5; wr_be = 4'hF; din = 32'hFFFFFFFF;
        for (int i = 0; i < 10; i++) begin
            idle();
            checks++;
            if (rd_valid !== 1'b0 || init_busy !== 1'b1)
                begin failures++; $display("FAIL busy_ignore cyc=%0d v=%b busy=%b exp v=0 busy=1", i, rd_valid, init_busy); end
        end
        rd_en = 1'b0; wr_en = 1'b0;
        wait_clear(n);
        checks++;
        if (n !== 1014) begin failures++; $display("FAIL busy_clear_len got=%0d exp=1014", n); end
        issue(1'b1, 10'h5, 1'b0, 10'd0, 4'h0, 32'h0);
        repeat (LAT-1) idle();
        e = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || dout !== e || e !== 32'h0)
            begin failures++; $display("FAIL busy_write_dropped v=%b got=%h exp=%h", rd_valid, dout, e); end
    endtask

    task automatic test_mid_reset();
        int n;
        logic [31:0] e;
        issue(1'b0, 10'd0, 1'b1, 10'h12, 4'hF, 32'h12345678);
        rd_en = 1'b1; rd_addr = 10'h12;
        idle();
        reset = 1'b1;
        idle();
        checks++;
        if (rd_valid !== 1'b0 || init_busy !== 1'b1)
            begin failures++; $display("FAIL mid_reset v=%b busy=%b exp v=0 busy=1", rd_valid, init_busy); end
        reset = 1'b0; rd_en = 1'b0;
        repeat (300) idle();
        checks++;
        if (init_busy !== 1'b1) begin failures++; $display("FAIL mid_clear_busy got=%b exp=1", init_busy); end
        reset = 1'b1;
        idle();
        reset = 1'b0;
        wait_clear(n);
        checks++;
        if (n !== 1024) begin failures++; $display("FAIL restart_clear_len got=%0d exp=1024", n); end
        issue(1'b1, 10'h12, 1'b0, 10'd0, 4'h0, 32'h0);
        repeat (LAT-1) idle();
        e = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || dout !== e || e !== 32'h0)
            begin failures++; $display("FAIL restart_rd v=%b got=%h exp=%h", rd_valid, dout, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        int guard;
        for (int a = 0; a < 16; a++) issue(1'b0, 10'd0, 1'b1, 10'(a), 4'hF, 32'(a));
        for (int a = 0; a < 16; a++) begin
            issue(1'b1, 10'(a), 1'b0, 10'd0, 4'h0, 32'h0);
            rd_en = (a < 15);
            rd_addr = 10'(a + 1);
            if (exp_q.size() >= LAT) begin
                e = exp_q.pop_front();
                checks++;
                if (rd_valid !== 1'b1 || dout !== e)
                    begin failures++; $display("FAIL b2b a=%0d v=%b got=%h exp=%h", a, rd_valid, dout, e); end
            end
        end
        rd_en = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 4) begin
            idle();
            guard++;
            e = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || dout !== e)
                begin failures++; $display("FAIL b2b_tail v=%b got=%h exp=%h", rd_valid, dout, e); end
        end
    endtask

    initial begin
        test_reset();
        test_lane_write();
        test_forward();
        test_busy_ignore();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
